// File: rtl/key_digit_editor.sv
// Single-button BCD setting editor: a long press enters edit mode and walks digit
// positions from most to least significant, a short press increments the selected digit.
`timescale 1ns/1ps

module key_digit_editor #(
    parameter int IN_C_HZ   = 50_000_000,
    parameter int DIGITS    = 4,
    parameter int BLINK_MS  = 250,
    parameter int TIMEOUT_S = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_short,
    input  logic                      key_long,
    output logic [4*DIGITS-1:0]       value,
    output logic [4*DIGITS-1:0]       edit_value,
    output logic [$clog2(DIGITS)-1:0] sel,
    output logic                      edit_active,
    output logic                      blink,
    output logic                      commit
);

    localparam int SEL_W = $clog2(DIGITS);

    // Terminal counts are evaluated in 64 bits so large clock rates cannot overflow.
    localparam logic [63:0] BLINK_TC   = 64'(BLINK_MS) * 64'(IN_C_HZ / 1000) - 64'd1;
    localparam logic [63:0] TIMEOUT_TC = 64'(TIMEOUT_S) * 64'(IN_C_HZ) - 64'd1;
    localparam int BLINK_W = $clog2(BLINK_TC) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_TC) + 1;
    localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_TC);
    localparam logic [TO_W-1:0]    TO_END    = TO_W'(TIMEOUT_TC);
    localparam logic [SEL_W-1:0]   SEL_MSD   = SEL_W'(DIGITS - 1);

    typedef enum logic {
        IDLE,
        EDIT
    } state_t;

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  value_q, value_d;
    logic [4*DIGITS-1:0]  edit_value_q, edit_value_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 edit_active_q, edit_active_d;
    logic                 blink_q, blink_d;
    logic                 commit_q, commit_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [3:0]           digit_cur;
    logic [3:0]           digit_next;

    always_comb begin
        digit_cur  = edit_value_q[{sel_q, 2'b00} +: 4];
        digit_next = (digit_cur == 4'd9) ? 4'd0 : digit_cur + 4'd1;
    end

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        edit_value_d  = edit_value_q;
        sel_d         = sel_q;
        edit_active_d = edit_active_q;
        blink_d       = blink_q;
        commit_d      = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        to_cnt_d      = to_cnt_q;

        case (state_q)
            IDLE: begin
                edit_value_d  = value_q;
                sel_d         = '0;
                edit_active_d = 1'b0;
                blink_d       = 1'b0;
                blink_cnt_d   = '0;
                to_cnt_d      = '0;
                if (key_long) begin
                    state_d       = EDIT;
                    sel_d         = SEL_MSD;
                    edit_active_d = 1'b1;
                    blink_d       = 1'b1;
                end
            end

            EDIT: begin
                if (key_long || key_short) begin
                    blink_cnt_d = '0;
                    to_cnt_d    = '0;
                    blink_d     = 1'b1;
                    // key_long wins when both pulses arrive together
                    if (key_long) begin
                        if (sel_q != '0) begin
                            sel_d = sel_q - SEL_W'(1);
                        end else begin
                            value_d       = edit_value_q;
                            commit_d      = 1'b1;
                            state_d       = IDLE;
                            sel_d         = '0;
                            edit_active_d = 1'b0;
                            blink_d       = 1'b0;
                        end
                    end else begin
                        edit_value_d[{sel_q, 2'b00} +: 4] = digit_next;
                    end
                end else if (to_cnt_q == TO_END) begin
                    edit_value_d  = value_q;
                    state_d       = IDLE;
                    sel_d         = '0;
                    edit_active_d = 1'b0;
                    blink_d       = 1'b0;
                    blink_cnt_d   = '0;
                    to_cnt_d      = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (blink_cnt_q == BLINK_END) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            value_q       <= '0;
            edit_value_q  <= '0;
            sel_q         <= '0;
            edit_active_q <= 1'b0;
            blink_q       <= 1'b0;
            commit_q      <= 1'b0;
            blink_cnt_q   <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            edit_value_q  <= edit_value_d;
            sel_q         <= sel_d;
            edit_active_q <= edit_active_d;
            blink_q       <= blink_d;
            commit_q      <= commit_d;
            blink_cnt_q   <= blink_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign value       = value_q;
    assign edit_value  = edit_value_q;
    assign sel         = sel_q;
    assign edit_active = edit_active_q;
    assign blink       = blink_q;
    assign commit      = commit_q;

endmodule
